// File: rtl/branch_flag_gen.sv
// Multi-cycle A-B (or A-0) comparator producing Zero/Sign/OverFlow branch flags.
// Subtracts STEP bits per cycle LSB-first; flags are held between operations.
module branch_flag_gen #(
  parameter int WIDTH = 32,
  parameter int STEP  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [5:0]       OP,
  output logic             busy,
  output logic             done,
  output logic             Zero,
  output logic             Sign,
  output logic             OverFlow
);

  localparam int N     = WIDTH / STEP;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] a_sh, b_sh;
  logic             carry, zacc;
  logic [STEP:0]    s;
  logic             cin_msb, chunk_zero, last, two_op;

  function automatic logic [STEP:0] chunk_sub(input logic [STEP-1:0] a,
                                              input logic [STEP-1:0] b,
                                              input logic            cin);
    chunk_sub = {1'b0, a} + {1'b0, ~b} + {{STEP{1'b0}}, cin};
  endfunction

  always_comb begin
    s          = chunk_sub(a_sh[STEP-1:0], b_sh[STEP-1:0], carry);
    // Carry into the chunk MSB recovered from sum = a ^ ~b ^ cin.
    cin_msb    = s[STEP-1] ^ a_sh[STEP-1] ^ ~b_sh[STEP-1];
    chunk_zero = (s[STEP-1:0] == '0);
    last       = (cnt == LAST);
    two_op     = (OP == 6'b000100) || (OP == 6'b000101);
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Control and flag registers
  always_ff @(posedge clk) begin
    if (rst) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      Zero     <= 1'b0;
      Sign     <= 1'b0;
      OverFlow <= 1'b0;
      cnt      <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          busy <= 1'b1;
          cnt  <= '0;
        end
        RUN: begin
          cnt <= last ? '0 : cnt + 1'b1;
          if (last) begin
            busy     <= 1'b0;
            done     <= 1'b1;
            Zero     <= zacc & chunk_zero;
            Sign     <= s[STEP-1];
            OverFlow <= cin_msb ^ s[STEP];
          end
        end
        default: ;
      endcase
    end
  end

  // Datapath: operands, running carry and zero accumulator
  always_ff @(posedge clk) begin
    case (state)
      IDLE: if (start) begin
        a_sh  <= A;
        b_sh  <= two_op ? B : '0;
        carry <= 1'b1;
        zacc  <= 1'b1;
      end
      RUN: begin
        a_sh  <= a_sh >> STEP;
        b_sh  <= b_sh >> STEP;
        carry <= s[STEP];
        zacc  <= zacc & chunk_zero;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_branch_flag_gen.sv
// Self-checking bench for branch_flag_gen: directed branch cases, random ops,
// handshake corner cases and reset abort against a whole-word reference model.
module tb_branch_flag_gen;
  localparam int WIDTH = 32;
  localparam int STEP  = 8;
  localparam int N     = WIDTH / STEP;

  logic             clk = 1'b0;
  logic             rst, start;
  logic [WIDTH-1:0] A, B;
  logic [5:0]       OP;
  logic             busy, done, Zero, Sign, OverFlow;

  int n_cmp = 0;
  int n_bad = 0;

  branch_flag_gen #(.WIDTH(WIDTH), .STEP(STEP)) dut (
    .clk(clk), .rst(rst), .start(start), .A(A), .B(B), .OP(OP),
    .busy(busy), .done(done), .Zero(Zero), .Sign(Sign), .OverFlow(OverFlow)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: whole-word two's-complement subtraction, flags packed {Z,S,O}.
  function automatic logic [2:0] model(input logic [WIDTH-1:0] a,
                                       input logic [WIDTH-1:0] b,
                                       input logic [5:0] op);
    logic [WIDTH-1:0] sub, r;
    sub = (op == 6'd4 || op == 6'd5) ? b : '0;
    r   = a - sub;
    return {r == '0, r[WIDTH-1], (a[WIDTH-1] != sub[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1])};
  endfunction

  // Drives one start cycle; returns #1 after the accepting edge with inputs scrambled.
  task automatic launch(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic [5:0] op);
    @(negedge clk);
    A = a; B = b; OP = op; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    A = $urandom; B = $urandom; OP = 6'($urandom);
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
    end while (!done && cyc < 50);
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; A = '0; B = '0; OP = '0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (busy !== 1'b0)     begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0)     begin n_bad++; $display("FAIL reset_done: got %b want 0", done); end
    n_cmp++; if ({Zero, Sign, OverFlow} !== 3'b000)
      begin n_bad++; $display("FAIL reset_flags: got %b want 000", {Zero, Sign, OverFlow}); end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_directed();
    logic [WIDTH-1:0] va[8] = '{32'd5, 32'h80000000, 32'h7FFFFFFF, 32'hFFFFFFFF,
                                32'd0, 32'h00000100, 32'h00010000, 32'h0000FFFF};
    logic [WIDTH-1:0] vb[8] = '{32'd5, 32'd1, 32'hFFFFFFFF, 32'h1234,
                                32'h55, 32'h000000FF, 32'h00010000, 32'h0000FFFF};
    logic [5:0]       vo[8] = '{6'd4, 6'd5, 6'd5, 6'd1, 6'd7, 6'd4, 6'd4, 6'd6};
    int cyc;
    logic [2:0] exp;
    for (int i = 0; i < 8; i++) begin
      exp = model(va[i], vb[i], vo[i]);
      launch(va[i], vb[i], vo[i]);
      n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL dir%0d_busy: got %b want 1", i, busy); end
      wait_done(cyc);
      n_cmp++; if (cyc != N) begin n_bad++; $display("FAIL dir%0d_latency: got %0d want %0d", i, cyc, N); end
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL dir%0d_busy_end: got %b want 0", i, busy); end
      n_cmp++; if ({Zero, Sign, OverFlow} !== exp)
        begin n_bad++; $display("FAIL dir%0d_flags: got %b want %b", i, {Zero, Sign, OverFlow}, exp); end
    end
  endtask

  task automatic test_random();
    logic [WIDTH-1:0] a, b;
    logic [5:0] op;
    logic [2:0] exp;
    int cyc;
    for (int i = 0; i < 40; i++) begin
      a  = $urandom;
      b  = ($urandom_range(0, 3) == 0) ? a : $urandom;
      case ($urandom_range(0, 3))
        0: op = 6'd4;
        1: op = 6'd5;
        2: op = 6'($urandom_range(1, 7));
        default: op = 6'($urandom);
      endcase
      if ($urandom_range(0, 4) == 0) a = {1'b1, {(WIDTH-1){1'b0}}} ^ 32'($urandom_range(0, 1));
      exp = model(a, b, op);
      launch(a, b, op);
      wait_done(cyc);
      n_cmp++; if (cyc != N || {Zero, Sign, OverFlow} !== exp)
        begin n_bad++; $display("FAIL rand%0d: a=%h b=%h op=%0d cyc=%0d got %b want %b",
                                i, a, b, op, cyc, {Zero, Sign, OverFlow}, exp); end
    end
  endtask

  task automatic test_busy_ignore();
    logic [2:0] exp, got;
    int ndone, at;
    exp = model(32'h80000000, 32'd1, 6'd5);
    launch(32'h80000000, 32'd1, 6'd5);          // edge k
    @(posedge clk); #1;                          // edge k+1
    A = 32'd7; B = 32'd7; OP = 6'd4; start = 1'b1;
    @(posedge clk); #1;                          // edge k+2
    start = 1'b0;
    ndone = 0; at = -1; got = '0;
    for (int i = 0; i < 8; i++) begin            // edges k+3 .. k+10
      @(posedge clk); #1;
      if (done) begin ndone++; at = i; got = {Zero, Sign, OverFlow}; end
    end
    n_cmp++; if (ndone != 1)     begin n_bad++; $display("FAIL ignore_count: got %0d want 1", ndone); end
    n_cmp++; if (at != N - 3)    begin n_bad++; $display("FAIL ignore_timing: got %0d want %0d", at, N - 3); end
    n_cmp++; if (got !== exp)    begin n_bad++; $display("FAIL ignore_flags: got %b want %b", got, exp); end
  endtask

  task automatic test_back_to_back();
    logic [2:0] e1, e2;
    int cyc;
    e1 = model(32'd5, 32'd5, 6'd4);
    e2 = model(32'h7FFFFFFF, 32'hFFFFFFFF, 6'd5);
    launch(32'd5, 32'd5, 6'd4);
    wait_done(cyc);
    n_cmp++; if (cyc != N || {Zero, Sign, OverFlow} !== e1)
      begin n_bad++; $display("FAIL b2b_first: cyc=%0d got %b want %b", cyc, {Zero, Sign, OverFlow}, e1); end
    A = 32'h7FFFFFFF; B = 32'hFFFFFFFF; OP = 6'd5; start = 1'b1;   // in the done cycle
    @(posedge clk); #1;
    start = 1'b0; A = $urandom; B = $urandom;
    n_cmp++; if (busy !== 1'b1 || done !== 1'b0)
      begin n_bad++; $display("FAIL b2b_accept: got busy=%b done=%b want busy=1 done=0", busy, done); end
    // Flags from the first op must still be visible while the second runs.
    n_cmp++; if ({Zero, Sign, OverFlow} !== e1)
      begin n_bad++; $display("FAIL hold_during_run: got %b want %b", {Zero, Sign, OverFlow}, e1); end
    wait_done(cyc);
    n_cmp++; if (cyc != N || {Zero, Sign, OverFlow} !== e2)
      begin n_bad++; $display("FAIL b2b_second: cyc=%0d got %b want %b", cyc, {Zero, Sign, OverFlow}, e2); end
    repeat (5) @(posedge clk);
    #1;
    n_cmp++; if ({Zero, Sign, OverFlow} !== e2 || done !== 1'b0)
      begin n_bad++; $display("FAIL hold_idle: got %b done=%b want %b done=0", {Zero, Sign, OverFlow}, done, e2); end
  endtask

  task automatic test_reset_mid();
    logic [2:0] exp;
    int ndone, cyc;
    launch(32'hFFFFFFFF, 32'h0, 6'd1);          // edge k
    @(posedge clk); #1;                          // edge k+1
    rst = 1'b1;
    @(posedge clk); #1;                          // edge k+2
    n_cmp++; if (busy !== 1'b0 || done !== 1'b0)
      begin n_bad++; $display("FAIL abort_ctrl: got busy=%b done=%b want 0 0", busy, done); end
    n_cmp++; if ({Zero, Sign, OverFlow} !== 3'b000)
      begin n_bad++; $display("FAIL abort_flags: got %b want 000", {Zero, Sign, OverFlow}); end
    rst = 1'b0;
    ndone = 0;
    for (int i = 0; i < N + 3; i++) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    n_cmp++; if (ndone != 0) begin n_bad++; $display("FAIL abort_done: got %0d want 0", ndone); end
    exp = model(32'h00000100, 32'h000000FF, 6'd4);
    launch(32'h00000100, 32'h000000FF, 6'd4);
    wait_done(cyc);
    n_cmp++; if (cyc != N || {Zero, Sign, OverFlow} !== exp)
      begin n_bad++; $display("FAIL after_reset: cyc=%0d got %b want %b", cyc, {Zero, Sign, OverFlow}, exp); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
